// File: rtl/cms_trace_receiver.sv
// AXI-Stream trace packet receiver: 2-entry skid buffer, field unpack, burst framing checks and
// end-of-program tracking. Define CMS_RX_TIMESTAMP_EN to build the absolute timestamp accumulator.
module cms_trace_receiver #(
  parameter int INSTR_WIDTH                      = 32,
  parameter int CLK_COUNTER_WIDTH                = 64,
  parameter int XLEN                             = 64,
  parameter int NO_OF_PERFORMANCE_EVENTS         = 115,
  parameter int PERF_COUNTER_WIDTH               = 7,
  parameter logic [INSTR_WIDTH-1:0] WFI_INSTRUCTION = 32'h10500073,
  localparam int PERF_W     = NO_OF_PERFORMANCE_EVENTS * PERF_COUNTER_WIDTH,
  localparam int DATA_WIDTH = INSTR_WIDTH + CLK_COUNTER_WIDTH + XLEN + PERF_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         S_AXIS_tvalid,
  output logic                         S_AXIS_tready,
  input  logic [DATA_WIDTH-1:0]        S_AXIS_tdata,
  input  logic                         S_AXIS_tlast,
  input  logic [31:0]                  tlast_interval,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic [XLEN-1:0]              out_pc,
  output logic [CLK_COUNTER_WIDTH-1:0] out_clk_delta,
  output logic [PERF_W-1:0]            out_perf_counters,
  output logic                         out_tlast,
  output logic [CLK_COUNTER_WIDTH-1:0] out_timestamp,
  output logic [31:0]                  pkt_count,
  output logic                         stopped,
  output logic                         err_unexpected_tlast,
  output logic                         err_missing_tlast
);

  // state      | meaning
  // ST_IDLE    | no beat accepted since reset/clear
  // ST_RUN     | program running, beats flowing
  // ST_STOPPED | last beat was WFI closing a burst
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPED} state_e;

  localparam int INSTR_LSB = DATA_WIDTH - INSTR_WIDTH;
  localparam int DELTA_LSB = INSTR_LSB - CLK_COUNTER_WIDTH;

  state_e                  state_q, state_d;
  logic                    init_q;
  logic [DATA_WIDTH-1:0]   data_q [2];
  logic [1:0]              last_q;
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              count_q, count_d;
  logic [31:0]             beat_idx_q, beat_idx_d;
  logic [31:0]             pkt_count_q, pkt_count_d;
  logic                    err_unexp_q, err_unexp_d;
  logic                    err_miss_q, err_miss_d;
  logic                    full, empty, push, pop;
  logic                    beat_wfi, last_expected;
  logic [INSTR_WIDTH-1:0]  in_instr;
  logic [DATA_WIDTH-1:0]   head;

  assign in_instr      = S_AXIS_tdata[DATA_WIDTH-1 -: INSTR_WIDTH];
  assign full          = (count_q == 2'd2);
  assign empty         = (count_q == 2'd0);
  // init_q holds tready low until the first clock after reset release
  assign S_AXIS_tready = init_q & ~full & ~clear;
  assign push          = S_AXIS_tvalid & S_AXIS_tready;
  assign pop           = ~empty & out_ready;
  assign beat_wfi      = (in_instr == WFI_INSTRUCTION);
  assign last_expected = ((tlast_interval != 32'd0) && (beat_idx_q + 32'd1 == tlast_interval))
                         || beat_wfi;

  always_comb begin
    count_d     = count_q;
    beat_idx_d  = beat_idx_q;
    pkt_count_d = pkt_count_q;
    err_unexp_d = err_unexp_q;
    err_miss_d  = err_miss_q;
    if (clear) begin
      count_d     = 2'd0;
      beat_idx_d  = 32'd0;
      pkt_count_d = 32'd0;
      err_unexp_d = 1'b0;
      err_miss_d  = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
        pkt_count_d = pkt_count_q + 32'd1;
        beat_idx_d  = S_AXIS_tlast ? 32'd0 : beat_idx_q + 32'd1;
        if (S_AXIS_tlast && !last_expected) err_unexp_d = 1'b1;
        if (!S_AXIS_tlast && last_expected) err_miss_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (push) begin
      case (state_q)
        ST_IDLE:    state_d = ST_RUN;
        ST_RUN:     if (beat_wfi && S_AXIS_tlast) state_d = ST_STOPPED;
        ST_STOPPED: state_d = ST_RUN;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q      <= 1'b0;
      state_q     <= ST_IDLE;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      beat_idx_q  <= 32'd0;
      pkt_count_q <= 32'd0;
      err_unexp_q <= 1'b0;
      err_miss_q  <= 1'b0;
    end else begin
      init_q      <= 1'b1;
      state_q     <= state_d;
      count_q     <= count_d;
      beat_idx_q  <= beat_idx_d;
      pkt_count_q <= pkt_count_d;
      err_unexp_q <= err_unexp_d;
      err_miss_q  <= err_miss_d;
      if (clear) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_q ^ push;
        rd_ptr_q <= rd_ptr_q ^ pop;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= 2'b00;
    end else if (push) begin
      data_q[wr_ptr_q] <= S_AXIS_tdata;
      last_q[wr_ptr_q] <= S_AXIS_tlast;
    end
  end

  assign head                 = data_q[rd_ptr_q];
  assign out_valid            = ~empty;
  assign out_instr            = head[DATA_WIDTH-1 -: INSTR_WIDTH];
  assign out_clk_delta        = head[INSTR_LSB-1 -: CLK_COUNTER_WIDTH];
  assign out_pc               = head[DELTA_LSB-1 -: XLEN];
  assign out_perf_counters    = head[PERF_W-1:0];
  assign out_tlast            = last_q[rd_ptr_q];
  assign pkt_count            = pkt_count_q;
  assign stopped              = (state_q == ST_STOPPED);
  assign err_unexpected_tlast = err_unexp_q;
  assign err_missing_tlast    = err_miss_q;

`ifdef CMS_RX_TIMESTAMP_EN
  logic [CLK_COUNTER_WIDTH-1:0] in_delta, ts_acc_q, ts_sum;
  logic [CLK_COUNTER_WIDTH-1:0] ts_q [2];

  assign in_delta = S_AXIS_tdata[INSTR_LSB-1 -: CLK_COUNTER_WIDTH];
  assign ts_sum   = ts_acc_q + in_delta;

  // each entry carries the post-add timestamp of its own beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_acc_q <= '0;
      ts_q[0]  <= '0;
      ts_q[1]  <= '0;
    end else if (clear) begin
      ts_acc_q <= '0;
    end else if (push) begin
      ts_acc_q         <= ts_sum;
      ts_q[wr_ptr_q]   <= ts_sum;
    end
  end

  assign out_timestamp = ts_q[rd_ptr_q];
`else
  assign out_timestamp = '0;
`endif

endmodule

// File: tb/tb_cms_trace_receiver.sv
// Scoreboard bench for cms_trace_receiver: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the packet stream.
module tb_cms_trace_receiver;

  localparam int IW = 32;
  localparam int CW = 64;
  localparam int XW = 64;
  localparam int PW = 115 * 7;
  localparam int DW = IW + CW + XW + PW;
  localparam logic [31:0] WFI = 32'h10500073;

  logic          clk = 1'b0;
  logic          rst_n, tvalid, tready, tlast, clear, out_valid, out_ready, out_tlast;
  logic [DW-1:0] tdata;
  logic [31:0]   tlast_interval, pkt_count, out_instr;
  logic [63:0]   out_pc, out_clk_delta, out_timestamp;
  logic [PW-1:0] out_perf;
  logic          stopped, err_u, err_m;

  cms_trace_receiver dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(tvalid), .S_AXIS_tready(tready), .S_AXIS_tdata(tdata), .S_AXIS_tlast(tlast),
    .tlast_interval(tlast_interval), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_clk_delta(out_clk_delta), .out_perf_counters(out_perf), .out_tlast(out_tlast),
    .out_timestamp(out_timestamp), .pkt_count(pkt_count), .stopped(stopped),
    .err_unexpected_tlast(err_u), .err_missing_tlast(err_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   instr;
    logic [63:0]   delta;
    logic [63:0]   pc;
    logic [PW-1:0] perf;
    logic          last;
    logic [63:0]   ts;
    int            acc_cyc;
  } beat_t;

  beat_t       sb[$];
  beat_t       mon_e;
  int          n_tests = 0, n_fail = 0, cyc = 0;
  bit          lat_chk = 0, m_init = 0;
  logic [31:0] m_pkt = 0, m_bidx = 0;
  bit          m_eu = 0, m_em = 0, m_started = 0, m_stopped = 0;
  logic [63:0] m_ts = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [PW-1:0] rand_perf();
    logic [PW-1:0] v = '0;
    for (int i = 0; i < PW; i += 32) v = (v << 32) | PW'($urandom);
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] v = $urandom;
    if (v == WFI) v = v ^ 32'h1;
    return v;
  endfunction

  function automatic void model_clear();
    sb.delete();
    m_pkt = 0; m_bidx = 0; m_eu = 0; m_em = 0;
    m_started = 0; m_stopped = 0; m_ts = 0;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_init = 0; else m_init = 1;

  // Offers one beat, waits (bounded) for acceptance, then folds it into the model.
  task automatic send(input logic [31:0] ins, input logic [63:0] dl, input logic [63:0] pc_v,
                      input logic lst);
    beat_t       b;
    int          n = 0;
    bit          done = 0;
    bit          exp_l;
    logic [31:0] nxt;
    b.instr = ins; b.delta = dl; b.pc = pc_v; b.perf = rand_perf(); b.last = lst;
    tvalid = 1; tdata = {ins, dl, pc_v, b.perf}; tlast = lst;
    while (!done) begin
      @(negedge clk);
      if (tready) begin
        @(posedge clk); #1;
        nxt   = m_bidx + 32'd1;
        exp_l = ((tlast_interval != 0) && (nxt == tlast_interval)) || (ins == WFI);
        if (lst && !exp_l) m_eu = 1;
        if (!lst && exp_l) m_em = 1;
        m_bidx = lst ? 32'd0 : nxt;
        if (!m_started) m_started = 1;
        else if (m_stopped) m_stopped = 0;
        else if (ins == WFI && lst) m_stopped = 1;
        m_pkt = m_pkt + 32'd1;
`ifdef CMS_RX_TIMESTAMP_EN
        m_ts = m_ts + dl;
        b.ts = m_ts;
`else
        b.ts = 0;
`endif
        b.acc_cyc = cyc;
        sb.push_back(b);
        done = 1;
      end else begin
        n++;
        if (n > 200) begin
          chk("accept_timeout", 1, 0);
          @(posedge clk); #1;
          done = 1;
        end
      end
    end
    tvalid = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    model_clear();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: checks handshake/status every cycle and pops the scoreboard on each output transfer.
  always @(negedge clk) begin
    chk("out_valid", out_valid, sb.size() != 0);
    chk("tready", tready, m_init && sb.size() < 2 && !clear);
    chk("pkt_count", pkt_count, m_pkt);
    chk("err_unexpected", err_u, m_eu);
    chk("err_missing", err_m, m_em);
    chk("stopped", stopped, m_stopped);
    if (out_valid && out_ready && sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("out_instr", out_instr, mon_e.instr);
      chk("out_pc", out_pc, mon_e.pc);
      chk("out_clk_delta", out_clk_delta, mon_e.delta);
      chk("out_perf_eq", out_perf == mon_e.perf, 1);
      chk("out_tlast", out_tlast, mon_e.last);
      chk("out_timestamp", out_timestamp, mon_e.ts);
      if (lat_chk) chk("latency", cyc, mon_e.acc_cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; tvalid = 0; tlast = 0; tdata = '0; clear = 0; out_ready = 0; tlast_interval = 0;
    repeat (3) @(negedge clk);
    chk("rst_tready", tready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_ts", out_timestamp, 0);
    rst_n = 1;
    #1 chk("tready_low_at_release", tready, 0);
    @(posedge clk); #1;
    chk("tready_after_release", tready, 1);

    // back-to-back, one cycle latency
    out_ready = 1; lat_chk = 1;
    send(rand_instr(), 64'd1, 64'h8000_0000, 0);
    send(rand_instr(), 64'd1, 64'h8000_0004, 0);
    send(rand_instr(), 64'd1, 64'h8000_0008, 0);
    @(negedge clk); #1;
    chk("pkt_count_3", pkt_count, 3);
    lat_chk = 0;
    idle(2);

    // backpressure
    out_ready = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) send(rand_instr(), 64'd2, 64'h9000_0000 + 64'(i * 4), 0);
      end
      begin
        idle(8);
        chk("bp_tready", tready, 0);
        chk("bp_pkt_count", pkt_count, 5);
        out_ready = 1;
      end
    join
    idle(4);

    // framing with interval 4
    do_clear();
    tlast_interval = 4;
    for (int i = 0; i < 4; i++) send(rand_instr(), 64'd1, 64'h100 + 64'(i), i == 3);
    @(negedge clk); #1;
    chk("int4_ok_u", err_u, 0);
    chk("int4_ok_m", err_m, 0);
    @(posedge clk); #1;
    do_clear();
    for (int i = 0; i < 3; i++) send(rand_instr(), 64'd1, 64'h200 + 64'(i), i == 2);
    @(negedge clk); #1;
    chk("int4_early_u", err_u, 1);
    @(posedge clk); #1;
    do_clear();
    for (int i = 0; i < 4; i++) send(rand_instr(), 64'd1, 64'h300 + 64'(i), 0);
    @(negedge clk); #1;
    chk("int4_late_m", err_m, 1);
    chk("int4_late_u", err_u, 0);
    @(posedge clk); #1;

    // end of program
    do_clear();
    tlast_interval = 0;
    send(rand_instr(), 64'd1, 64'h400, 0);
    send(WFI, 64'd1, 64'h404, 1);
    @(negedge clk); #1;
    chk("wfi_stopped", stopped, 1);
    chk("wfi_no_err_u", err_u, 0);
    chk("wfi_no_err_m", err_m, 0);
    @(posedge clk); #1;
    send(rand_instr(), 64'd1, 64'h408, 0);
    @(negedge clk); #1;
    chk("wfi_resume", stopped, 0);
    @(posedge clk); #1;

    // timestamp accumulation with wrap
    do_clear();
    send(rand_instr(), 64'd5, 64'h500, 0);
    send(rand_instr(), 64'd10, 64'h504, 0);
    send(rand_instr(), 64'hFFFF_FFFF_FFFF_FFFF, 64'h508, 0);
    idle(3);

    // clear with two beats buffered and tvalid high
    out_ready = 0;
    send(rand_instr(), 64'd3, 64'h600, 1);
    send(rand_instr(), 64'd3, 64'h604, 0);
    tvalid = 1; tdata = {rand_instr(), 64'd3, 64'h608, rand_perf()}; tlast = 0; clear = 1;
    @(negedge clk);
    chk("clear_tready", tready, 0);
    @(posedge clk); #1;
    clear = 0; tvalid = 0; model_clear();
    @(negedge clk); #1;
    chk("clear_out_valid", out_valid, 0);
    chk("clear_pkt", pkt_count, 0);
    chk("clear_err_u", err_u, 0);
    out_ready = 1;
    @(posedge clk); #1;
    send(WFI, 64'd1, 64'h700, 1);
    @(negedge clk); #1;
    chk("clear_idle_state", stopped, 0);
    @(posedge clk); #1;
    idle(2);

    // asynchronous reset mid-burst
    out_ready = 0;
    send(rand_instr(), 64'd4, 64'h800, 1);
    send(rand_instr(), 64'd4, 64'h804, 0);
    tvalid = 1; tdata = {rand_instr(), 64'd4, 64'h808, rand_perf()};
    #2 rst_n = 0; model_clear();
    #1;
    chk("arst_tready", tready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_pkt", pkt_count, 0);
    chk("arst_err_u", err_u, 0);
    chk("arst_out_pc", out_pc, 0);
    tvalid = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("arst_tready_back", tready, 1);
    out_ready = 1;
    send(WFI, 64'd1, 64'h900, 1);
    @(negedge clk); #1;
    chk("arst_idle_state", stopped, 0);
    @(posedge clk); #1;
    idle(2);

    // randomized traffic with random backpressure
    begin
      bit rnd_done = 0;
      int ivals[4] = '{0, 2, 3, 5};
      fork
        begin
          for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            logic        l;
            if ($urandom % 10 == 0) tlast_interval = ivals[$urandom % 4];
            if ($urandom % 60 == 0) do_clear();
            if ($urandom % 4 == 0) idle($urandom_range(1, 3));
            if ($urandom % 6 == 0) begin
              ins = WFI; l = ($urandom % 4 != 0);
            end else begin
              ins = rand_instr(); l = ($urandom % 4 == 0);
            end
            send(ins, {$urandom, $urandom}, {$urandom, $urandom}, l);
          end
          rnd_done = 1;
        end
        begin
          while (!rnd_done) begin
            @(posedge clk); #1;
            out_ready = ($urandom % 3 != 0);
          end
        end
      join
    end
    out_ready = 1;
    idle(4);
    @(negedge clk); #1;
    chk("drain_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
